// File: rtl/bitmap_alloc_pkg.sv
// Shared types and constants for the multi-port bitmap block allocator.
package bitmap_alloc_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 128;
    localparam int DEF_NREL        = 2;
    localparam int DEF_AMFULL_DIFF = 4;

    typedef enum logic [1:0] {
        S_GRP,
        S_ROW,
        S_OFR
    } state_t;

    // Index width for an N-entry vector; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Block address width: {row index, bit index}.
    function automatic int addr_w(input int width, input int depth);
        return idx_w(width) + idx_w(depth);
    endfunction

endpackage

// File: rtl/bitmap_alloc_if.sv
// Allocate/release/status bundle between the cache managers and the allocator.
interface bitmap_alloc_if
    import bitmap_alloc_pkg::*;
#(
    parameter int ADDR_W = addr_w(DEF_WIDTH, DEF_DEPTH),
    parameter int NREL   = DEF_NREL
);
    logic                   cand_vld;
    logic [ADDR_W-1:0]      cand_addr;
    logic                   alloc_take;
    logic [NREL-1:0]        rel_vld;
    logic [NREL*ADDR_W-1:0] rel_addr;
    logic [ADDR_W:0]        used_num;
    logic [ADDR_W:0]        free_num;
    logic                   full;
    logic                   almost_full;
    logic                   empty;
    logic                   err_dfree;
    logic                   err_take;

    // Ingress/egress controllers: take offers, release blocks.
    modport master (
        input  cand_vld, cand_addr, used_num, free_num,
               full, almost_full, empty, err_dfree, err_take,
        output alloc_take, rel_vld, rel_addr
    );

    // Allocator side.
    modport slave (
        output cand_vld, cand_addr, used_num, free_num,
               full, almost_full, empty, err_dfree, err_take,
        input  alloc_take, rel_vld, rel_addr
    );
endinterface

// File: rtl/bitmap_alloc_mp_ffz_enc.sv
// First-zero priority encoder, bit 0 has the highest priority.
module ffz_enc
    import bitmap_alloc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]        vec,
    output logic                found,
    output logic [idx_w(N)-1:0] idx
);
    localparam int W = idx_w(N);

    // Scan from the top down so the lowest zero is the last one written.
    always_comb begin
        found = ~&vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vec[i]) idx = W'(i);
        end
    end
endmodule

// File: rtl/bitmap_alloc_mp.sv
// Multi-port bitmap free-block allocator (1 = used, 0 = free).
// Offers the lowest free block via valid/take, accepts NREL releases per cycle.
// Optional macro BITMAP_ALLOC_PEAK_EN adds the peak_used high-water mark port.
//
// state | meaning
// ------+-----------------------------------------------------------
// S_GRP | latch index of first row with a free bit; park here if full
// S_ROW | latch {row, first free bit} as the candidate address
// S_OFR | candidate offered (cand_vld=1) until alloc_take
module bitmap_alloc_mp
    import bitmap_alloc_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int NREL        = DEF_NREL,
    parameter int AMFULL_DIFF = DEF_AMFULL_DIFF
) (
    input  logic          clk,
    input  logic          rst,
    bitmap_alloc_if.slave bus
`ifdef BITMAP_ALLOC_PEAK_EN
    ,
    output logic [addr_w(WIDTH, DEPTH):0] peak_used
`endif
);
    localparam int ROW_W  = idx_w(WIDTH);
    localparam int COL_W  = idx_w(DEPTH);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int TOTAL  = WIDTH * DEPTH;
    localparam logic [ADDR_W:0] TOTAL_V = (ADDR_W + 1)'(TOTAL);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bmap [DEPTH];
    logic [DEPTH-1:0]    grp;
    logic                grp_found;
    logic [COL_W-1:0]    grp_idx;
    logic [COL_W-1:0]    row_q;
    logic [WIDTH-1:0]    sel_row;
    logic                row_found;
    logic [ROW_W-1:0]    bit_idx;
    logic [ADDR_W-1:0]   cand_q;
    logic [ADDR_W:0]     used_q;
    logic [ADDR_W:0]     rel_cnt;
    logic [ADDR_W-1:0]   rel_a [NREL];
    logic [NREL-1:0]     rel_eff;
    logic                dfree_hit;
    logic                dup;
    logic                cand_vld;
    logic                take_eff;
    logic                ld_row;
    logic                ld_cand;
    logic                full;
    logic                err_dfree_q;
    logic                err_take_q;

    // Row summary: a row is "full" when all its bits are used.
    always_comb begin
        grp = '0;
        for (int d = 0; d < DEPTH; d++) grp[d] = &bmap[d];
    end

    ffz_enc #(.N(DEPTH)) u_grp_enc (
        .vec   (grp),
        .found (grp_found),
        .idx   (grp_idx)
    );

    assign sel_row = bmap[row_q];

    ffz_enc #(.N(WIDTH)) u_row_enc (
        .vec   (sel_row),
        .found (row_found),
        .idx   (bit_idx)
    );

    // Split the packed release address bus into per-port addresses.
    always_comb begin
        for (int k = 0; k < NREL; k++) rel_a[k] = bus.rel_addr[k*ADDR_W +: ADDR_W];
    end

    // A release counts only if its bit is set and no lower port hits the same address.
    always_comb begin
        rel_eff   = '0;
        dfree_hit = 1'b0;
        dup       = 1'b0;
        for (int k = 0; k < NREL; k++) begin
            dup = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (bus.rel_vld[j] && (rel_a[j] == rel_a[k])) dup = 1'b1;
            end
            if (bus.rel_vld[k]) begin
                if (!dup && bmap[rel_a[k][ADDR_W-1:ROW_W]][rel_a[k][ROW_W-1:0]])
                    rel_eff[k] = 1'b1;
                else
                    dfree_hit = 1'b1;
            end
        end
    end

    // Number of blocks freed this cycle.
    always_comb begin
        rel_cnt = '0;
        for (int k = 0; k < NREL; k++) rel_cnt = rel_cnt + {{ADDR_W{1'b0}}, rel_eff[k]};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_GRP;
        else     state_q <= state_d;
    end

    // FSM next state; an offer is held until taken, even if a lower block frees up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GRP:   if (!full && grp_found) state_d = S_ROW;
            S_ROW:   state_d = S_OFR;
            S_OFR:   if (bus.alloc_take) state_d = S_GRP;
            default: state_d = S_GRP;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cand_vld = 1'b0;
        ld_row   = 1'b0;
        ld_cand  = 1'b0;
        case (state_q)
            S_GRP:   ld_row   = 1'b1;
            S_ROW:   ld_cand  = row_found;
            S_OFR:   cand_vld = 1'b1;
            default: ;
        endcase
    end

    assign take_eff = cand_vld & bus.alloc_take;

    // Search pipeline registers: selected row, then full candidate address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            cand_q <= '0;
        end else begin
            if (ld_row)  row_q  <= grp_idx;
            if (ld_cand) cand_q <= {row_q, bit_idx};
        end
    end

    // Bitmap update; a take never collides with an effective release (its bit is free).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) bmap[d] <= '0;
        end else begin
            for (int k = 0; k < NREL; k++) begin
                if (rel_eff[k]) bmap[rel_a[k][ADDR_W-1:ROW_W]][rel_a[k][ROW_W-1:0]] <= 1'b0;
            end
            if (take_eff) bmap[cand_q[ADDR_W-1:ROW_W]][cand_q[ROW_W-1:0]] <= 1'b1;
        end
    end

    // Used count and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_q      <= '0;
            err_dfree_q <= 1'b0;
            err_take_q  <= 1'b0;
        end else begin
            used_q <= used_q + {{ADDR_W{1'b0}}, take_eff} - rel_cnt;
            if (dfree_hit)                   err_dfree_q <= 1'b1;
            if (bus.alloc_take && !cand_vld) err_take_q  <= 1'b1;
        end
    end

`ifdef BITMAP_ALLOC_PEAK_EN
    logic [ADDR_W:0] peak_q;

    // High-water mark of the used count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  peak_q <= '0;
        else if (used_q > peak_q) peak_q <= used_q;
    end

    assign peak_used = peak_q;
`endif

    assign full             = (used_q == TOTAL_V);
    assign bus.cand_vld     = cand_vld;
    assign bus.cand_addr    = cand_q;
    assign bus.used_num     = used_q;
    assign bus.free_num     = TOTAL_V - used_q;
    assign bus.full         = full;
    assign bus.almost_full  = (32'(TOTAL_V - used_q) <= AMFULL_DIFF);
    assign bus.empty        = (used_q == '0);
    assign bus.err_dfree    = err_dfree_q;
    assign bus.err_take     = err_take_q;
endmodule

// File: tb/tb_bitmap_alloc_mp.sv
// Directed bench for bitmap_alloc_mp with a cycle-level reference model.
module tb_bitmap_alloc_mp;
    import bitmap_alloc_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 128;
    localparam int NREL   = 2;
    localparam int AMF    = 4;
    localparam int ADDR_W = 10;
    localparam int TOTAL  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bitmap_alloc_if #(.ADDR_W(ADDR_W), .NREL(NREL)) bus ();

`ifdef BITMAP_ALLOC_PEAK_EN
    logic [ADDR_W:0] peak_used;
`endif

    bitmap_alloc_mp #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREL(NREL), .AMFULL_DIFF(AMF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BITMAP_ALLOC_PEAK_EN
        ,
        .peak_used (peak_used)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: set of used blocks, count, and offer timing
    // (offer appears two edges after a search starts; a search waits while full).
    bit m_used [TOTAL];
    int m_cnt;
    int m_phase;
    int m_cand;
    bit m_edf;
    bit m_etk;
    int m_peak;

    function automatic int lowest_free();
        for (int i = 0; i < TOTAL; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int  pre_cnt;
        int  nxt;
        int  a;
        bit  tk;
        bit  dp;
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) m_used[i] = 1'b0;
            m_cnt = 0; m_phase = 0; m_cand = 0;
            m_edf = 1'b0; m_etk = 1'b0; m_peak = 0;
        end else begin
            pre_cnt = m_cnt;
            nxt = (m_phase == 1) ? lowest_free() : m_cand;
            tk  = (m_phase == 2) && bus.alloc_take;
            if (bus.alloc_take && (m_phase != 2)) m_etk = 1'b1;
            for (int k = 0; k < NREL; k++) begin
                if (bus.rel_vld[k]) begin
                    a  = int'(bus.rel_addr[k*ADDR_W +: ADDR_W]);
                    dp = 1'b0;
                    for (int j = 0; j < k; j++)
                        if (bus.rel_vld[j] && int'(bus.rel_addr[j*ADDR_W +: ADDR_W]) == a) dp = 1'b1;
                    if (!dp && m_used[a]) begin
                        m_used[a] = 1'b0;
                        m_cnt--;
                    end else begin
                        m_edf = 1'b1;
                    end
                end
            end
            if (tk) begin
                m_used[m_cand] = 1'b1;
                m_cnt++;
            end
            case (m_phase)
                0: if (pre_cnt != TOTAL) m_phase = 1;
                1: begin m_cand = nxt; m_phase = 2; end
                default: if (tk) m_phase = 0;
            endcase
            if (m_cnt > m_peak) m_peak = m_cnt;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cand_vld", bus.cand_vld, (m_phase == 2));
            if (m_phase == 2) chk("cand_addr", bus.cand_addr, m_cand);
            chk("used_num", bus.used_num, m_cnt);
            chk("free_num", bus.free_num, TOTAL - m_cnt);
            chk("full", bus.full, (m_cnt == TOTAL));
            chk("almost_full", bus.almost_full, ((TOTAL - m_cnt) <= AMF));
            chk("empty", bus.empty, (m_cnt == 0));
            chk("err_dfree", bus.err_dfree, m_edf);
            chk("err_take", bus.err_take, m_etk);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_offer();
        int w;
        w = 0;
        while (!bus.cand_vld && w < 8) begin
            tick();
            w++;
        end
        chk("offer_timeout", bus.cand_vld, 1);
    endtask

    task automatic take_one(input int exp);
        wait_offer();
        if (bus.cand_vld) begin
            chk("take_addr", bus.cand_addr, exp);
            bus.alloc_take = 1'b1;
            tick();
            bus.alloc_take = 1'b0;
        end
    endtask

    task automatic rel(input logic [NREL-1:0] v, input int a0, input int a1);
        bus.rel_vld  = v;
        bus.rel_addr = {ADDR_W'(a1), ADDR_W'(a0)};
        tick();
        bus.rel_vld  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_take = 1'b0;
        bus.rel_vld    = '0;
        bus.rel_addr   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Startup: offer after two edges.
        tick();
        chk("start_vld_e1", bus.cand_vld, 0);
        tick();
        chk("start_vld_e2", bus.cand_vld, 1);
        chk("start_addr", bus.cand_addr, 0);
        chk("start_free", bus.free_num, 1024);
        chk("start_empty", bus.empty, 1);

        // Take everything in address order.
        for (int i = 0; i < TOTAL; i++) begin
            take_one(i);
            if (i == 1018) chk("amf_1019", bus.almost_full, 0);
            if (i == 1019) chk("amf_1020", bus.almost_full, 1);
        end
        chk("full_after_all", bus.full, 1);
        chk("free_after_all", bus.free_num, 0);
        repeat (4) tick();
        chk("no_offer_full", bus.cand_vld, 0);

        // Release 517 on port 1 from full.
        rel(2'b10, 0, 517);
        chk("rel517_used", bus.used_num, 1023);
        chk("rel517_full", bus.full, 0);
        chk("rel517_vld_e1", bus.cand_vld, 0);
        tick();
        chk("rel517_vld_e2", bus.cand_vld, 0);
        tick();
        chk("rel517_vld", bus.cand_vld, 1);
        chk("rel517_addr", bus.cand_addr, 517);
        take_one(517);
        chk("refull", bus.full, 1);

        // Asynchronous reset in the middle of an offer.
        rel(2'b01, 0, 0);
        wait_offer();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vld", bus.cand_vld, 0);
        chk("async_rst_used", bus.used_num, 0);
        chk("async_rst_full", bus.full, 0);
        @(negedge clk);
        rst = 1'b0;

        // Blocks 0..9 used, offering 10.
        for (int i = 0; i < 10; i++) take_one(i);
        wait_offer();
        chk("offer10", bus.cand_addr, 10);
        rel(2'b11, 5, 5);
        chk("dual5_used", bus.used_num, 9);
        chk("dual5_err", bus.err_dfree, 1);
        rel(2'b01, 3, 0);
        chk("rel3_used", bus.used_num, 8);
        chk("hold10_a", bus.cand_addr, 10);
        tick();
        chk("hold10_b", bus.cand_addr, 10);
        take_one(10);
        take_one(3);
        take_one(5);
        wait_offer();
        chk("used_11", bus.used_num, 11);
        chk("offer11", bus.cand_addr, 11);

        // Fresh start for error and mixed cases.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) take_one(i);
        wait_offer();
        chk("clean_dfree", bus.err_dfree, 0);
        rel(2'b01, 700, 0);
        chk("rel700_err", bus.err_dfree, 1);
        chk("rel700_used", bus.used_num, 4);
        take_one(4);
        chk("vld_low_after_take", bus.cand_vld, 0);
        bus.alloc_take = 1'b1;
        tick();
        bus.alloc_take = 1'b0;
        chk("err_take", bus.err_take, 1);
        chk("bad_take_used", bus.used_num, 5);
        wait_offer();
        chk("offer5", bus.cand_addr, 5);
        bus.alloc_take = 1'b1;
        rel(2'b01, 5, 0);
        bus.alloc_take = 1'b0;
        chk("take_rel_same_used", bus.used_num, 6);
        wait_offer();
        chk("offer6", bus.cand_addr, 6);
        bus.alloc_take = 1'b1;
        rel(2'b01, 1, 0);
        bus.alloc_take = 1'b0;
        chk("take_rel_diff_used", bus.used_num, 6);
        wait_offer();
        chk("offer1", bus.cand_addr, 1);
        rel(2'b11, 0, 2);
        chk("rel_two_used", bus.used_num, 4);
        take_one(1);
        take_one(0);
        take_one(2);
        take_one(7);
        chk("final_used", bus.used_num, 8);
        tick();
`ifdef BITMAP_ALLOC_PEAK_EN
        chk("peak_model", peak_used, m_peak);
        chk("peak_literal", peak_used, 8);
`endif
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
